a3_tree_pipe: RTL and testbench
===============================

# a3_tree_pipe

Parametrised, pipelined N-input AND/NAND reduction built from 3-input AND levels, with a valid/ready handshake on both sides. It is the sequential, width-generalised successor of the fixed 3-input AND cell. It is used wherever a wide AND (all-ones detect, multi-source grant or match) must close timing at speed. Each tree level is one register stage, so the critical path is a single 3-input AND plus handshake logic.

## Interface
- WIDTH, 9: number of input bits; legal values are 1 to 243.
- INV, 0: output mode. 0 gives q = AND of all inputs; 1 gives q = NAND of all inputs.
- LEVELS, derived (not overridable): smallest L ≥ 1 with 3^L ≥ WIDTH. Pipeline depth equals LEVELS.

- ck  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i  input  WIDTH  operand bits.
- i_v  input  1  operand valid.
- i_rdy  output  1  block can accept an operand this cycle.
- q  output  1  reduction result.
- q_v  output  1  result valid.
- q_rdy  input  1  downstream accepts the result this cycle.

## Operation
- Level k (k = 0 … LEVELS-1) holds a data vector of width ceil(WIDTH/3^(k+1)) and a valid flag v[k].
- Level 0 loads groups of 3 bits from i: bit j = i[3j] & i[3j+1] & i[3j+2].
- Each later level ANDs groups of 3 bits from the previous level in the same way.
- In any incomplete group, missing bits are padded with 1, the identity for AND.
- The last level is 1 bit wide and stores the result already XORed with INV. q is this register; q_v = v[LEVELS-1].
- Stage control:
  - adv[LEVELS-1] = v[LEVELS-1] & q_rdy.
  - adv[k] = v[k] & (!v[k+1] | adv[k+1]).
  - Level k+1 loads when adv[k] is true. Level 0 loads when i_v & i_rdy.
  - v[k] is set on load. It is cleared when the stage advances without a new load.
- i_rdy = !rst & (!v[0] | adv[0]). It is combinational from q_rdy through the ready chain; there is no skid buffer.
- A stalled stage holds its data and valid unchanged. Bubbles collapse: a stage with v=0 always accepts from the level below.
- Simultaneous events:
  - A stage may load and advance in the same cycle; it then holds the new data with v=1.
  - Input acceptance and output handoff can happen in the same cycle.
- Transfers are never duplicated or dropped while rst is low. Results leave in acceptance order.
- WIDTH=1 gives LEVELS=1. The single stage registers i[0]^INV; the missing bits are padded with 1.
- Reset mid-operation flushes every in-flight operand; nothing is reported for them.

## Timing
- Reset values: all v[k]=0, all data registers 0. Outputs: q=0, q_v=0, i_rdy=0 while rst is high.
- i_rdy=1 in the first cycle after rst falls.
- Latency: an operand accepted at edge n gives q_v=1 with its result after edge n+LEVELS-1. It is visible in cycle n+LEVELS when there are no stalls.
- Throughput: one result per cycle while q_rdy stays high.
- Capacity: LEVELS operands in flight.
- While q_v=1 and q_rdy=0, q and q_v are stable. When the pipe is full, i_rdy=0 in that same cycle.
- No combinational path from i or i_v to q or q_v. The only combinational input-to-output path is q_rdy to i_rdy.

## Test plan
- WIDTH=9, INV=0: send i=0x1FF, then 0x1FE, then 0x0FF back-to-back with q_rdy=1 -> q_v goes high 2 cycles after the first accept; q = 1, 0, 0 on consecutive cycles.
- WIDTH=10, INV=1 (LEVELS=3): send i=0x3FF then 0x1FF -> results q=0 then q=1, first appearing 3 cycles after accept; proves padding and NAND mode.
- Backpressure, WIDTH=9: hold q_rdy=0 and offer 3 operands -> exactly 2 accepted, then i_rdy=0. Release q_rdy -> both results delivered in order, and i_rdy rises in the same cycle q_rdy goes high.
- Bubbles: drive i_v in the pattern 1,0,1,0 with q_rdy=1 -> q_v follows the same pattern delayed by LEVELS; no spurious q_v pulses.
- Reset mid-flight: assert rst asynchronously with 2 operands in flight -> q_v=0, q=0 and i_rdy=0 immediately, without waiting for a clock edge. After release, i_rdy=1 and no stale results emerge.
- WIDTH=1, INV=0: i=1 then i=0 -> q=1 then q=0, each 1 cycle after accept.

Source files
------------

// File: rtl/a3_tree_pipe.sv
// a3_tree_pipe
// Pipelined N-input AND / NAND reduction built from 3-input AND levels.
// Each tree level is one register stage with its own valid flag. The stages
// hand off through a valid/ready chain, so the critical path per stage is a
// single 3-input AND plus the handshake logic.
//
// Parameters
//   WIDTH  : number of operand bits, legal range 1 .. 243
//   INV    : 0 -> q = AND of all bits, 1 -> q = NAND of all bits
//   LEVELS : derived, smallest L >= 1 with 3^L >= WIDTH (pipeline depth)
//
// Ports
//   ck     in   clock, rising edge
//   rst    in   asynchronous active-high reset, flushes the pipe
//   i      in   operand bits [WIDTH-1:0]
//   i_v    in   operand valid
//   i_rdy  out  operand accepted this cycle when i_v is also high
//   q      out  registered reduction result
//   q_v    out  result valid
//   q_rdy  in   downstream accepts the result this cycle
module a3_tree_pipe #(
   parameter int WIDTH = 9,
   parameter bit INV   = 1'b0
) (
   input  logic             ck,
   input  logic             rst,
   input  logic [WIDTH-1:0] i,
   input  logic             i_v,
   output logic             i_rdy,
   output logic             q,
   output logic             q_v,
   input  logic             q_rdy
);

   // Depth of the tree: smallest L >= 1 such that 3^L covers WIDTH.
   function automatic int calc_levels(input int w);
      int l;
      int p;
      l = 1;
      p = 3;
      while (p < w) begin
         p = p * 3;
         l = l + 1;
      end
      return l;
   endfunction

   // Width of tree level k: ceil(w / 3^(k+1)).
   function automatic int lvl_width(input int w, input int k);
      int p;
      p = 3;
      for (int j = 0; j < k; j++) begin
         p = p * 3;
      end
      return (w + p - 1) / p;
   endfunction

   localparam int LEVELS = calc_levels(WIDTH);

   // Per-level valid flags and advance strobes (content moves up this edge).
   logic [LEVELS-1:0] v;
   logic [LEVELS-1:0] adv;

   // Advance chain, evaluated from the output side downwards. A stage moves
   // its content up when the next stage is empty or is itself moving on,
   // which makes bubbles collapse without extra buffering.
   always_comb begin
      adv              = '0;
      adv[LEVELS-1]    = v[LEVELS-1] & q_rdy;
      for (int k = LEVELS - 2; k >= 0; k--) begin
         adv[k] = v[k] & (~v[k+1] | adv[k+1]);
      end
   end

   // Input side: forced low during reset so nothing is taken while flushing.
   assign i_rdy = ~rst & (~v[0] | adv[0]);

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int IW = (k == 0) ? WIDTH : lvl_width(WIDTH, k - 1);
      localparam int OW = lvl_width(WIDTH, k);

      logic [IW-1:0]   src;   // data feeding this level
      logic [3*OW-1:0] pad;   // src widened to whole groups of 3
      logic [OW-1:0]   red;   // 3-input AND of each group
      logic [OW-1:0]   nxt;   // value loaded into this level
      logic [OW-1:0]   d;     // level data register
      logic            vr;    // level valid register
      logic            ld;    // level loads this edge

      if (k == 0) begin : g_src
         assign src = i;
         assign ld  = i_v & i_rdy;
      end else begin : g_src
         assign src = g_lvl[k-1].d;
         assign ld  = adv[k-1];
      end

      // Missing bits of an incomplete group are 1, the identity for AND.
      if (3 * OW > IW) begin : g_pad
         assign pad = {{(3 * OW - IW){1'b1}}, src};
      end else begin : g_nopad
         assign pad = src;
      end

      // Group reduction for this level.
      always_comb begin
         red = '0;
         for (int j = 0; j < OW; j++) begin
            red[j] = &pad[3*j +: 3];
         end
      end

      // The output level is one bit wide and stores the result with the
      // polarity already applied, so q comes straight from a flop.
      if (k == LEVELS - 1) begin : g_last
         assign nxt = red ^ {OW{INV}};
         assign q   = d[0];
         assign q_v = vr;
      end else begin : g_mid
         assign nxt = red;
      end

      assign v[k] = vr;

      // Level register: load on handoff from below; when the content moves up
      // with no refill the level goes empty; otherwise it holds (stall).
      always_ff @(posedge ck or posedge rst) begin
         if (rst) begin
            d  <= '0;
            vr <= 1'b0;
         end else if (ld) begin
            d  <= nxt;
            vr <= 1'b1;
         end else if (adv[k]) begin
            vr <= 1'b0;
         end else begin
            vr <= vr;
         end
      end
   end

endmodule

// File: tb/tb_a3_tree_pipe.sv
// Self-checking bench for a3_tree_pipe with three instances:
//   a : WIDTH=9,  INV=0 (LEVELS=2)
//   b : WIDTH=10, INV=1 (LEVELS=3)
//   c : WIDTH=1,  INV=0 (LEVELS=1)
// A scoreboard per instance receives the expected result whenever an operand
// is accepted and compares it when the matching result is handed off.
module tb_a3_tree_pipe;

   logic       ck;
   logic       rst;

   logic [8:0] a_i;
   logic       a_iv, a_irdy, a_q, a_qv, a_qrdy;
   logic [9:0] b_i;
   logic       b_iv, b_irdy, b_q, b_qv, b_qrdy;
   logic [0:0] c_i;
   logic       c_iv, c_irdy, c_q, c_qv, c_qrdy;

   int chk_cnt;
   int pass_cnt;

   bit qa[$];
   bit qb[$];
   bit qc[$];
   bit ea, eb, ec;

   a3_tree_pipe #(.WIDTH(9), .INV(1'b0)) dut_a (
      .ck(ck), .rst(rst), .i(a_i), .i_v(a_iv), .i_rdy(a_irdy),
      .q(a_q), .q_v(a_qv), .q_rdy(a_qrdy)
   );

   a3_tree_pipe #(.WIDTH(10), .INV(1'b1)) dut_b (
      .ck(ck), .rst(rst), .i(b_i), .i_v(b_iv), .i_rdy(b_irdy),
      .q(b_q), .q_v(b_qv), .q_rdy(b_qrdy)
   );

   a3_tree_pipe #(.WIDTH(1), .INV(1'b0)) dut_c (
      .ck(ck), .rst(rst), .i(c_i), .i_v(c_iv), .i_rdy(c_irdy),
      .q(c_q), .q_v(c_qv), .q_rdy(c_qrdy)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // Scoreboard for a: push on accept, pop/compare on handoff.
   always @(negedge ck) begin
      if (!rst) begin
         if (a_iv && a_irdy) qa.push_back(a_i == 9'h1FF);
         if (a_qv && a_qrdy) begin
            chk_cnt++;
            if (qa.size() == 0) begin
               $display("FAIL a_scoreboard unexpected result q=%0d expected none", a_q);
            end else begin
               ea = qa.pop_front();
               if (a_q !== ea) $display("FAIL a_scoreboard q=%0d expected %0d", a_q, ea);
               else pass_cnt++;
            end
         end
      end
   end

   // Scoreboard for b (NAND mode).
   always @(negedge ck) begin
      if (!rst) begin
         if (b_iv && b_irdy) qb.push_back(b_i != 10'h3FF);
         if (b_qv && b_qrdy) begin
            chk_cnt++;
            if (qb.size() == 0) begin
               $display("FAIL b_scoreboard unexpected result q=%0d expected none", b_q);
            end else begin
               eb = qb.pop_front();
               if (b_q !== eb) $display("FAIL b_scoreboard q=%0d expected %0d", b_q, eb);
               else pass_cnt++;
            end
         end
      end
   end

   // Scoreboard for c (single bit).
   always @(negedge ck) begin
      if (!rst) begin
         if (c_iv && c_irdy) qc.push_back(c_i[0]);
         if (c_qv && c_qrdy) begin
            chk_cnt++;
            if (qc.size() == 0) begin
               $display("FAIL c_scoreboard unexpected result q=%0d expected none", c_q);
            end else begin
               ec = qc.pop_front();
               if (c_q !== ec) $display("FAIL c_scoreboard q=%0d expected %0d", c_q, ec);
               else pass_cnt++;
            end
         end
      end
   end

   task automatic test_reset();
      #2;
      chk_cnt++;
      if ({a_irdy, a_qv, a_q, b_irdy, b_qv, b_q, c_irdy, c_qv, c_q} !== 9'b0)
         $display("FAIL reset_outputs got %b expected 000000000",
                  {a_irdy, a_qv, a_q, b_irdy, b_qv, b_q, c_irdy, c_qv, c_q});
      else pass_cnt++;
      @(posedge ck); #1;
      rst = 1'b0;
      @(negedge ck);
      chk_cnt++;
      if ({a_irdy, b_irdy, c_irdy} !== 3'b111)
         $display("FAIL reset_release_rdy got %b expected 111", {a_irdy, b_irdy, c_irdy});
      else pass_cnt++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
      a_qrdy = 1'b1; b_qrdy = 1'b1; c_qrdy = 1'b1;
      while ((qa.size() + qb.size() + qc.size()) != 0 && n < 40) begin
         @(negedge ck);
         n++;
      end
      chk_cnt++;
      if ((qa.size() + qb.size() + qc.size()) != 0)
         $display("FAIL drain_timeout pending=%0d expected 0", qa.size() + qb.size() + qc.size());
      else pass_cnt++;
      @(posedge ck); #1;
   endtask

   task automatic test_back_to_back();
      a_qrdy = 1'b1;
      @(posedge ck); #1; a_i = 9'h1FF; a_iv = 1'b1;
      @(posedge ck); #1; a_i = 9'h1FE;
      @(negedge ck);
      chk_cnt++;
      if (a_qv !== 1'b0) $display("FAIL b2b_latency_early q_v=%0d expected 0", a_qv);
      else pass_cnt++;
      @(posedge ck); #1; a_i = 9'h0FF;
      @(negedge ck);
      chk_cnt++;
      if ({a_qv, a_q} !== 2'b11) $display("FAIL b2b_first q_v,q=%b expected 11", {a_qv, a_q});
      else pass_cnt++;
      @(posedge ck); #1; a_iv = 1'b0;
      @(negedge ck);
      chk_cnt++;
      if ({a_qv, a_q} !== 2'b10) $display("FAIL b2b_second q_v,q=%b expected 10", {a_qv, a_q});
      else pass_cnt++;
      @(posedge ck); #1;
      @(negedge ck);
      chk_cnt++;
      if ({a_qv, a_q} !== 2'b10) $display("FAIL b2b_third q_v,q=%b expected 10", {a_qv, a_q});
      else pass_cnt++;
      @(posedge ck); #1;
      @(negedge ck);
      chk_cnt++;
      if (a_qv !== 1'b0) $display("FAIL b2b_empty q_v=%0d expected 0", a_qv);
      else pass_cnt++;
   endtask

   task automatic test_nand_pad();
      bit exp_qv [5];
      bit exp_q  [5];
      exp_qv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      exp_q  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      b_qrdy = 1'b1;
      @(posedge ck); #1; b_i = 10'h3FF; b_iv = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge ck); #1;
         if (c == 0) b_i = 10'h1FF;
         else b_iv = 1'b0;
         @(negedge ck);
         chk_cnt++;
         if (b_qv !== exp_qv[c] || (exp_qv[c] && b_q !== exp_q[c]))
            $display("FAIL nand_pad_c%0d q_v,q=%b%b expected %b%b", c, b_qv, b_q, exp_qv[c], exp_q[c]);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      logic [8:0] ops [3];
      int acc;
      bit seen;
      ops = '{9'h1FF, 9'h0AA, 9'h1FF};
      acc = 0;
      a_qrdy = 1'b0; a_iv = 1'b1; a_i = ops[0];
      for (int c = 0; c < 5; c++) begin
         @(negedge ck);
         seen = a_irdy;
         @(posedge ck); #1;
         if (seen) acc++;
         a_i = ops[(acc > 2) ? 2 : acc];
      end
      chk_cnt++;
      if (acc != 2) $display("FAIL bp_accept_count got %0d expected 2", acc);
      else pass_cnt++;
      @(negedge ck);
      chk_cnt++;
      if ({a_irdy, a_qv, a_q} !== 3'b011)
         $display("FAIL bp_stall_state i_rdy,q_v,q=%b expected 011", {a_irdy, a_qv, a_q});
      else pass_cnt++;
      @(posedge ck); #1;
      a_iv = 1'b0;
      a_qrdy = 1'b1;
      #1;
      chk_cnt++;
      if (a_irdy !== 1'b1) $display("FAIL bp_rdy_same_cycle i_rdy=%0d expected 1", a_irdy);
      else pass_cnt++;
   endtask

   task automatic test_bubbles();
      bit pat [4];
      bit exp;
      pat = '{1'b1, 1'b0, 1'b1, 1'b0};
      a_qrdy = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge ck); #1;
         a_i  = (c == 2) ? 9'h1F7 : 9'h1FF;
         a_iv = (c < 4) ? pat[c] : 1'b0;
         @(negedge ck);
         exp = (c >= 2 && c < 6) ? pat[c-2] : 1'b0;
         chk_cnt++;
         if (a_qv !== exp) $display("FAIL bubble_c%0d q_v=%0d expected %0d", c, a_qv, exp);
         else pass_cnt++;
      end
      a_iv = 1'b0;
   endtask

   task automatic test_reset_midflight();
      a_qrdy = 1'b0;
      @(posedge ck); #1; a_i = 9'h1FF; a_iv = 1'b1;
      @(posedge ck); #1;
      @(posedge ck); #1; a_iv = 1'b0;
      #1;
      chk_cnt++;
      if ({a_qv, a_q} !== 2'b11) $display("FAIL mid_prefill q_v,q=%b expected 11", {a_qv, a_q});
      else pass_cnt++;
      #1;
      rst = 1'b1;
      qa.delete(); qb.delete(); qc.delete();
      #1;
      chk_cnt++;
      if ({a_qv, a_q, a_irdy} !== 3'b000)
         $display("FAIL mid_async_reset q_v,q,i_rdy=%b expected 000", {a_qv, a_q, a_irdy});
      else pass_cnt++;
      @(posedge ck); #1;
      rst = 1'b0;
      a_qrdy = 1'b1;
      @(negedge ck);
      chk_cnt++;
      if (a_irdy !== 1'b1) $display("FAIL mid_release_rdy i_rdy=%0d expected 1", a_irdy);
      else pass_cnt++;
      for (int c = 0; c < 5; c++) begin
         @(negedge ck);
         chk_cnt++;
         if (a_qv !== 1'b0) $display("FAIL mid_stale_c%0d q_v=%0d expected 0", c, a_qv);
         else pass_cnt++;
      end
   endtask

   task automatic test_width1();
      c_qrdy = 1'b1;
      @(posedge ck); #1; c_i = 1'b1; c_iv = 1'b1;
      @(posedge ck); #1; c_i = 1'b0;
      @(negedge ck);
      chk_cnt++;
      if ({c_qv, c_q} !== 2'b11) $display("FAIL w1_first q_v,q=%b expected 11", {c_qv, c_q});
      else pass_cnt++;
      @(posedge ck); #1; c_iv = 1'b0;
      @(negedge ck);
      chk_cnt++;
      if ({c_qv, c_q} !== 2'b10) $display("FAIL w1_second q_v,q=%b expected 10", {c_qv, c_q});
      else pass_cnt++;
      @(posedge ck); #1;
      @(negedge ck);
      chk_cnt++;
      if (c_qv !== 1'b0) $display("FAIL w1_empty q_v=%0d expected 0", c_qv);
      else pass_cnt++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      chk_cnt = 0;
      pass_cnt = 0;
      rst = 1'b1;
      a_i = '0; a_iv = 1'b0; a_qrdy = 1'b0;
      b_i = '0; b_iv = 1'b0; b_qrdy = 1'b0;
      c_i = '0; c_iv = 1'b0; c_qrdy = 1'b0;
      test_reset();
      test_back_to_back();
      drain();
      test_nand_pad();
      drain();
      test_backpressure();
      drain();
      test_bubbles();
      drain();
      test_reset_midflight();
      drain();
      test_width1();
      drain();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
